sdram_avl_arbiter: RTL
======================

# sdram_avl_arbiter

Round-robin arbiter that shares the single Avalon-style slave port of `sdram_controller` among `NUM_MASTERS` requesters (camera write path, HDMI read path, and similar). It grants one master per transaction and locks the grant for the whole burst. It steers that master's command to the slave and steers read responses back to the owning master only. It sits directly in front of `sdram_controller`; masters connect on flattened packed-vector ports, and master `i` occupies slice `i`.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesters, legal range 2..8.
- `OWNER_W`, `$clog2(NUM_MASTERS)`: width of the owner index.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rest`  in  1: synchronous, active-high reset.
- `m_address`  in  32*NUM_MASTERS: per-master byte address.
- `m_byte_en`  in  4*NUM_MASTERS: per-master write byte enables.
- `m_read`, `m_write`  in  NUM_MASTERS: per-master request strobes.
- `m_write_data`  in  32*NUM_MASTERS: per-master write word.
- `m_begin_burst_transfer`  in  NUM_MASTERS: per-master burst flag.
- `m_burst_count`  in  8*NUM_MASTERS: per-master burst length minus 1.
- `m_resp_ready`  in  NUM_MASTERS: per-master read-response pop.
- `m_request_ready`  out  NUM_MASTERS: per-master command-beat accept.
- `m_read_data`  out  32: read word, broadcast to all masters.
- `m_read_data_valid`  out  NUM_MASTERS: read-data valid, asserted for the owner only.
- `s_address`, `s_byte_en`, `s_read`, `s_write`, `s_write_data`, `s_begin_burst_transfer`, `s_burst_count`  out: command outputs to `sdram_controller`, same widths as one master slice.
- `s_resp_ready`  out  1: response pop to the slave.
- `s_request_ready`, `s_read_data_valid`  in  1: slave handshakes.
- `s_read_data`  in  32: slave read word.
- `busy`  out  1: a transaction is in progress (state is not IDLE).
- `owner`  out  OWNER_W: current or last granted master.

## Operation
- **Transaction length:** a transaction is `beats = m_burst_count+1` when `m_begin_burst_transfer=1`, else 1 beat. `beats` is 9 bits, range 1..256.
- **Beat accept:** a command beat is accepted in a cycle with `s_request_ready=1` and (`s_read` or `s_write`) asserted.
- **Response handshake:** a response completes in a cycle with `s_read_data_valid=1` and `s_resp_ready=1`.
- **States:** IDLE, CMD, RESP.
- **IDLE:**
  - All `s_*` command outputs are 0 and `s_resp_ready`=0.
  - The request vector is `m_read|m_write`.
  - If any bit is set, the winner is the first requester found searching upward from `owner+1`, wrapping modulo `NUM_MASTERS`.
  - On the next edge: latch `owner`, `is_read` (`m_read` has priority if both strobes are set), and `beats`; clear `cmd_cnt` and `rsp_cnt`; go to CMD.
- **CMD:**
  - `s_*` command outputs equal the owner's slice, combinational from the registered `owner`.
  - `m_request_ready[owner]` equals `s_request_ready`; every other master gets 0.
  - Each accepted beat increments `cmd_cnt`.
  - On the accept with `cmd_cnt==beats-1`: a write goes to IDLE; a read goes to RESP, or to IDLE if `rsp_cnt` already equals `beats` including this cycle.
- **RESP:** command outputs are 0. Go to IDLE on the response handshake that makes `rsp_cnt==beats`.
- **Response steering (CMD and RESP, read transactions only):**
  - `s_resp_ready` equals `m_resp_ready[owner]`.
  - `m_read_data_valid[owner]` equals `s_read_data_valid`.
  - `m_read_data` equals `s_read_data` at all times.
  - Each handshake increments `rsp_cnt`.
  - In write transactions both `s_resp_ready` and every `m_read_data_valid` are 0.
- **No mid-transaction arbitration:** new requests seen during CMD or RESP are not considered until the block returns to IDLE.
- **Master obligation:** the owner holds its strobe, address and burst fields stable until its last beat is accepted. If it drops the strobe in CMD, the arbiter stays in CMD with `s_read`/`s_write`=0. It does not abort.
- **Spurious responses:** an `s_read_data_valid` arriving in IDLE is not acknowledged; `s_resp_ready` stays 0.

## Timing
- **Reset values:** state=IDLE, `owner=NUM_MASTERS-1` (so master 0 wins first), `busy=0`, all counters 0, all `s_*` outputs 0, `m_request_ready=0`, `m_read_data_valid=0`.
- **Reset mid-transaction:** returns to IDLE on the next edge, drops all outputs, and discards the counts.
- **Grant latency:** a request first seen in IDLE at cycle N appears on `s_*` at cycle N+1.
- **Minimum gap:** one IDLE cycle separates back-to-back transactions, giving 1 bubble per transaction.
- **No throttling in CMD:** beats are accepted at the slave's rate; the arbiter adds no extra wait states.
- **Counter bounds:** `cmd_cnt` and `rsp_cnt` are 9 bits and never exceed `beats`. Responses beyond `beats` are not acknowledged.
- **Simultaneous events:**
  - The last response and the last command accept in the same cycle close the transaction directly to IDLE.
  - All masters requesting at once are served strictly in rotation.

## Test plan
- **Reset/idle:** hold `rest=1` for 3 cycles with `m_read=2'b11` -> all outputs 0. After release, master 0 is granted one cycle later and `owner=0`.
- **Single write:** master 1 single write, addr `0x100`, data `0xDEADBEEF` -> `s_write=1` with that data until one `s_request_ready`; then IDLE; `m_read_data_valid` never asserted.
- **Read burst:**
  - Stimulus: master 0 read with `burst_count=7`.
  - Required: 8 command accepts.
  - Required: `busy` stays 1 until the 8th response handshake.
  - Required: only `m_read_data_valid[0]` pulses, 8 times.
- **Fairness:** both masters request continuously with single reads -> grants alternate 0,1,0,1, with one IDLE cycle between transactions.
- **Lockout:** master 1 raises `m_write` while master 0's 4-beat read is in RESP -> master 1 sees `m_request_ready[1]=0` until master 0's 4th response, then is granted.
- **Overlap plus reset:**
  - Case 1: the last command accept and the last response land in the same cycle -> next state IDLE.
  - Case 2: `rest` pulsed mid-burst -> IDLE and all outputs 0 on the following cycle.

Source files
------------

// File: rtl/sdram_avl_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_avl_arbiter_if: master-side and slave-side Avalon-style buses   |
// | of the SDRAM arbiter.                  Revision: 1.0                  |
// +-----------------------------------------------------------------------+
interface sdram_avl_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [32*NUM_MASTERS-1:0] m_address;
  logic [4*NUM_MASTERS-1:0]  m_byte_en;
  logic [NUM_MASTERS-1:0]    m_read;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [32*NUM_MASTERS-1:0] m_write_data;
  logic [NUM_MASTERS-1:0]    m_begin_burst_transfer;
  logic [8*NUM_MASTERS-1:0]  m_burst_count;
  logic [NUM_MASTERS-1:0]    m_resp_ready;
  logic [NUM_MASTERS-1:0]    m_request_ready;
  logic [31:0]               m_read_data;
  logic [NUM_MASTERS-1:0]    m_read_data_valid;

  logic [31:0] s_address;
  logic [3:0]  s_byte_en;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_write_data;
  logic        s_begin_burst_transfer;
  logic [7:0]  s_burst_count;
  logic        s_resp_ready;
  logic        s_request_ready;
  logic        s_read_data_valid;
  logic [31:0] s_read_data;

  // The arbiter's view: slave to the requesters, master to the controller.
  modport slave (
    input  m_address, m_byte_en, m_read, m_write, m_write_data,
           m_begin_burst_transfer, m_burst_count, m_resp_ready,
           s_request_ready, s_read_data_valid, s_read_data,
    output m_request_ready, m_read_data, m_read_data_valid,
           s_address, s_byte_en, s_read, s_write, s_write_data,
           s_begin_burst_transfer, s_burst_count, s_resp_ready
  );

  modport master (
    output m_address, m_byte_en, m_read, m_write, m_write_data,
           m_begin_burst_transfer, m_burst_count, m_resp_ready,
           s_request_ready, s_read_data_valid, s_read_data,
    input  m_request_ready, m_read_data, m_read_data_valid,
           s_address, s_byte_en, s_read, s_write, s_write_data,
           s_begin_burst_transfer, s_burst_count, s_resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/sdram_avl_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_avl_arbiter: round-robin, burst-locked arbiter sharing one      |
// | sdram_controller slave port among NUM_MASTERS requesters. Rev: 1.0    |
// +-----------------------------------------------------------------------+
module sdram_avl_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
  input  logic               clk,
  input  logic               rest,
  sdram_avl_arbiter_if.slave bus,
  output logic               busy,
  output logic [OWNER_W-1:0] owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [OWNER_W-1:0] r_owner, w_owner_nxt;
  logic               r_is_read, w_is_read_nxt;
  logic [8:0]         r_beats, w_beats_nxt;
  logic [8:0]         r_cmd_cnt, w_cmd_cnt_nxt;
  logic [8:0]         r_rsp_cnt, w_rsp_cnt_nxt;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_found;
  logic [OWNER_W-1:0]     w_winner;
  logic                   w_accept;
  logic                   w_resp_open;
  logic                   w_resp_hs;

  assign w_req           = bus.m_read | bus.m_write;
  assign bus.m_read_data = bus.s_read_data;
  assign busy            = (r_state != S_IDLE);
  assign owner           = r_owner;

  // Rotating search starting just above the last owner.
  always_comb begin : p_pick
    logic [OWNER_W:0] w_idx;
    w_found  = 1'b0;
    w_winner = r_owner;
    w_idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_idx = {1'b0, r_owner} + (OWNER_W+1)'(k);
      if (w_idx >= (OWNER_W+1)'(NUM_MASTERS)) begin
        w_idx = w_idx - (OWNER_W+1)'(NUM_MASTERS);
      end
      if (!w_found && w_req[w_idx[OWNER_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[OWNER_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      r_state   <= S_IDLE;
      r_owner   <= OWNER_W'(NUM_MASTERS-1);
      r_is_read <= 1'b0;
      r_beats   <= 9'd0;
      r_cmd_cnt <= 9'd0;
      r_rsp_cnt <= 9'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_is_read <= w_is_read_nxt;
      r_beats   <= w_beats_nxt;
      r_cmd_cnt <= w_cmd_cnt_nxt;
      r_rsp_cnt <= w_rsp_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_is_read_nxt = r_is_read;
    w_beats_nxt   = r_beats;
    w_cmd_cnt_nxt = r_cmd_cnt;
    w_rsp_cnt_nxt = r_rsp_cnt;

    bus.s_address              = 32'd0;
    bus.s_byte_en              = 4'd0;
    bus.s_read                 = 1'b0;
    bus.s_write                = 1'b0;
    bus.s_write_data           = 32'd0;
    bus.s_begin_burst_transfer = 1'b0;
    bus.s_burst_count          = 8'd0;
    bus.s_resp_ready           = 1'b0;
    bus.m_request_ready        = '0;
    bus.m_read_data_valid      = '0;

    w_accept    = 1'b0;
    w_resp_hs   = 1'b0;
    // Responses past the expected count are left unacknowledged.
    w_resp_open = r_is_read && (r_rsp_cnt != r_beats);

    if (r_state != S_IDLE && w_resp_open) begin
      bus.s_resp_ready               = bus.m_resp_ready[r_owner];
      bus.m_read_data_valid[r_owner] = bus.s_read_data_valid;
      w_resp_hs = bus.s_read_data_valid && bus.m_resp_ready[r_owner];
    end
    if (w_resp_hs) begin
      w_rsp_cnt_nxt = r_rsp_cnt + 9'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_CMD;
          w_owner_nxt   = w_winner;
          w_is_read_nxt = bus.m_read[w_winner];
          w_beats_nxt   = bus.m_begin_burst_transfer[w_winner]
                        ? {1'b0, bus.m_burst_count[8*w_winner +: 8]} + 9'd1
                        : 9'd1;
          w_cmd_cnt_nxt = 9'd0;
          w_rsp_cnt_nxt = 9'd0;
        end
      end
      S_CMD: begin
        bus.s_address              = bus.m_address[32*r_owner +: 32];
        bus.s_byte_en              = bus.m_byte_en[4*r_owner +: 4];
        bus.s_read                 = bus.m_read[r_owner];
        bus.s_write                = bus.m_write[r_owner];
        bus.s_write_data           = bus.m_write_data[32*r_owner +: 32];
        bus.s_begin_burst_transfer = bus.m_begin_burst_transfer[r_owner];
        bus.s_burst_count          = bus.m_burst_count[8*r_owner +: 8];
        bus.m_request_ready[r_owner] = bus.s_request_ready;
        w_accept = bus.s_request_ready
                 && (bus.m_read[r_owner] || bus.m_write[r_owner]);
        if (w_accept) begin
          w_cmd_cnt_nxt = r_cmd_cnt + 9'd1;
          if (r_cmd_cnt == r_beats - 9'd1) begin
            if (!r_is_read || w_rsp_cnt_nxt == r_beats) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_RESP;
            end
          end
        end
      end
      S_RESP: begin
        if (w_resp_hs && w_rsp_cnt_nxt == r_beats) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
